// File: rtl/uart_frame_parser.sv
// Host frame parser between the UART receiver and the matrix/vector feeder.
// Validates FE/LEN/CMD/payload/EF frames and emits registered feeder strobes.
module uart_frame_parser #(
    parameter int MAX_N          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] rec_data,
    output logic       size_m_en,
    output logic       enable_mat,
    output logic       enable_vec,
    output logic       enb_assign,
    output logic       clear,
    output logic       start,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_CMD, S_PAYLOAD, S_TAIL} state_e;
    typedef enum logic [2:0] {C_NONE, C_SIZE, C_START, C_CLEAR, C_MAT, C_VEC} cmd_e;

    state_e        state_q, state_d;
    cmd_e          cmd_q, cmd_d, cmd_dec;
    logic [7:0]    len_q, len_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    pend_q, pend_d;
    logic [3:0]    size_q, size_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rec_data_d;
    logic          size_m_en_d, enable_mat_d, enable_vec_d, clear_d, start_d, frame_err_d;
    logic [6:0]    nn;
    logic [7:0]    exp_len;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the next-state logic below is purely combinational.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= C_NONE;
            len_q      <= '0;
            rem_q      <= '0;
            pend_q     <= '0;
            size_q     <= '0;
            tmo_q      <= '0;
            rec_data   <= '0;
            size_m_en  <= 1'b0;
            enable_mat <= 1'b0;
            enable_vec <= 1'b0;
            enb_assign <= 1'b0;
            clear      <= 1'b0;
            start      <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            pend_q     <= pend_d;
            size_q     <= size_d;
            tmo_q      <= tmo_d;
            rec_data   <= rec_data_d;
            size_m_en  <= size_m_en_d;
            enable_mat <= enable_mat_d;
            enable_vec <= enable_vec_d;
            enb_assign <= enable_mat_d | enable_vec_d;
            clear      <= clear_d;
            start      <= start_d;
            frame_err  <= frame_err_d;
            busy       <= (state_d != S_IDLE);
        end
    end

    // Opcode decode and the LEN each opcode demands (N*N kept to 7 bits).
    always_comb begin
        nn = {3'b000, size_q} * {3'b000, size_q};
        case (rx_data)
            8'h01:   begin cmd_dec = C_SIZE;  exp_len = 8'd2; end
            8'h02:   begin cmd_dec = C_START; exp_len = 8'd1; end
            8'h03:   begin cmd_dec = C_CLEAR; exp_len = 8'd1; end
            8'h04:   begin cmd_dec = C_MAT;   exp_len = {1'b0, nn} + 8'd1; end
            8'h05:   begin cmd_dec = C_VEC;   exp_len = {4'h0, size_q} + 8'd1; end
            default: begin cmd_dec = C_NONE;  exp_len = 8'd0; end
        endcase
    end

    // NOTE: every variable gets its default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        len_d        = len_q;
        rem_d        = rem_q;
        pend_d       = pend_q;
        size_d       = size_q;
        tmo_d        = tmo_q;
        rec_data_d   = rec_data;
        size_m_en_d  = 1'b0;
        enable_mat_d = 1'b0;
        enable_vec_d = 1'b0;
        clear_d      = 1'b0;
        start_d      = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q != S_IDLE && !rx_valid) begin
            if (tmo_q == TMO_LAST) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else if (rx_valid) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: if (rx_data == 8'hFE) state_d = S_LEN;
                S_LEN: begin
                    if (rx_data == 8'd0) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        len_d   = rx_data;
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    if (cmd_dec == C_NONE || len_q != exp_len ||
                        ((cmd_dec == C_MAT || cmd_dec == C_VEC) && size_q == 4'd0)) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        cmd_d = cmd_dec;
                        rem_d = len_q - 8'd1;
                        state_d = (len_q == 8'd1) ? S_TAIL : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    case (cmd_q)
                        C_MAT:   begin enable_mat_d = 1'b1; rec_data_d = rx_data; end
                        C_VEC:   begin enable_vec_d = 1'b1; rec_data_d = rx_data; end
                        C_SIZE:  pend_d = rx_data;
                        default: ;
                    endcase
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = S_TAIL;
                end
                S_TAIL: begin
                    state_d = S_IDLE;
                    if (rx_data != 8'hEF) begin
                        frame_err_d = 1'b1;
                    end else begin
                        case (cmd_q)
                            C_SIZE: begin
                                if (pend_q == 8'd0 || pend_q > 8'(MAX_N)) begin
                                    frame_err_d = 1'b1;
                                end else begin
                                    size_d      = pend_q[3:0];
                                    size_m_en_d = 1'b1;
                                    rec_data_d  = pend_q - 8'd1;
                                end
                            end
                            C_START: start_d = 1'b1;
                            C_CLEAR: begin
                                clear_d = 1'b1;
                                size_d  = 4'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser.
// A negedge monitor logs every strobe; each scenario compares the logs against hand-derived results.
module tb_uart_frame_parser;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] rec_data;
    logic       size_m_en, enable_mat, enable_vec, enb_assign, clear, start, frame_err, busy;

    uart_frame_parser #(.MAX_N(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rec_data(rec_data), .size_m_en(size_m_en), .enable_mat(enable_mat),
        .enable_vec(enable_vec), .enb_assign(enb_assign), .clear(clear),
        .start(start), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_size, n_clr, n_start, n_err, n_multi, n_enb_bad;
    logic [7:0] last_size;
    logic [7:0] mat_q[$];
    logic [7:0] vec_q[$];
    logic [7:0] q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if ($countones({size_m_en, enable_mat, enable_vec, clear, start, frame_err}) > 1) n_multi++;
        if (enb_assign !== (enable_mat | enable_vec)) n_enb_bad++;
        if (size_m_en) begin n_size++; last_size = rec_data; end
        if (enable_mat) mat_q.push_back(rec_data);
        if (enable_vec) vec_q.push_back(rec_data);
        if (clear) n_clr++;
        if (start) n_start++;
        if (frame_err) n_err++;
    end

    task automatic clr_counts();
        n_size = 0; n_clr = 0; n_start = 0; n_err = 0;
        last_size = 8'h00;
        mat_q.delete();
        vec_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered at posedge+1; each byte occupies exactly one cycle, so sequences are back-to-back.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
    endtask

    function automatic logic [7:0] outs();
        return {busy, size_m_en, enable_mat, enable_vec, enb_assign, clear, start, frame_err};
    endfunction

    initial begin
        n_multi = 0; n_enb_bad = 0;
        clr_counts();
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs()), 32'h0);
        check("reset_rec_data", 32'(rec_data), 32'h0);
        rst = 1'b1;
        idle(2);

        // VECTOR before any size is set: rejected at CMD, rest ignored in IDLE
        clr_counts();
        q = '{8'hFE, 8'h04, 8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hEF};
        send_q(q); idle(3);
        check("nosize_err", 32'(n_err), 32'd1);
        check("nosize_vec", 32'(vec_q.size()), 32'd0);
        check("nosize_busy", 32'(busy), 32'd0);

        // SET_SIZE N=3
        clr_counts();
        send(8'hFE);
        check("size_busy_rise", 32'(busy), 32'd1);
        q = '{8'h02, 8'h01, 8'h03, 8'hEF};
        send_q(q); idle(3);
        check("size_pulse", 32'(n_size), 32'd1);
        check("size_rec", 32'(last_size), 32'h02);
        check("size_err", 32'(n_err), 32'd0);
        check("size_busy_fall", 32'(busy), 32'd0);

        // MATRIX N=3: nine streamed bytes
        clr_counts();
        send(8'hFE); send(8'h0A); send(8'h04);
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        send(8'hEF); idle(3);
        check("mat_count", 32'(mat_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < mat_q.size(); i++)
            check($sformatf("mat_byte%0d", i), 32'(mat_q[i]), 32'h10 + 32'(i));
        check("mat_err", 32'(n_err), 32'd0);

        // VECTOR N=3 whose payload contains the delimiter values
        clr_counts();
        q = '{8'hFE, 8'h04, 8'h05, 8'hFE, 8'hEF, 8'h07, 8'hEF};
        send_q(q); idle(3);
        check("vec_count", 32'(vec_q.size()), 32'd3);
        if (vec_q.size() == 3) begin
            check("vec_b0", 32'(vec_q[0]), 32'hFE);
            check("vec_b1", 32'(vec_q[1]), 32'hEF);
            check("vec_b2", 32'(vec_q[2]), 32'h07);
        end
        check("vec_err", 32'(n_err), 32'd0);

        // MATRIX with wrong LEN, then LEN=0
        clr_counts();
        q = '{8'hFE, 8'h05, 8'h04, 8'h01, 8'h02};
        send_q(q); idle(3);
        check("matlen_err", 32'(n_err), 32'd1);
        check("matlen_none", 32'(mat_q.size()), 32'd0);
        clr_counts();
        send(8'hFE); send(8'h00); idle(3);
        check("len0_err", 32'(n_err), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);

        // Bad tail then good START
        clr_counts();
        q = '{8'hFE, 8'h01, 8'h02, 8'h00};
        send_q(q); idle(3);
        check("badtail_err", 32'(n_err), 32'd1);
        check("badtail_start", 32'(n_start), 32'd0);
        clr_counts();
        q = '{8'hFE, 8'h01, 8'h02, 8'hEF};
        send_q(q); idle(3);
        check("start_pulse", 32'(n_start), 32'd1);
        check("start_err", 32'(n_err), 32'd0);

        // SET_SIZE N=9 rejected at tail; N stays 3
        clr_counts();
        q = '{8'hFE, 8'h02, 8'h01, 8'h09, 8'hEF};
        send_q(q); idle(3);
        check("size9_err", 32'(n_err), 32'd1);
        check("size9_pulse", 32'(n_size), 32'd0);
        clr_counts();
        q = '{8'hFE, 8'h04, 8'h05, 8'h01, 8'h02, 8'h03, 8'hEF};
        send_q(q); idle(3);
        check("keep3_vec", 32'(vec_q.size()), 32'd3);
        check("keep3_err", 32'(n_err), 32'd0);

        // N=4 then CLEAR; afterwards VECTOR is rejected (no size)
        clr_counts();
        q = '{8'hFE, 8'h02, 8'h01, 8'h04, 8'hEF};
        send_q(q); idle(3);
        check("size4_rec", 32'(last_size), 32'h03);
        clr_counts();
        q = '{8'hFE, 8'h01, 8'h03, 8'hEF};
        send_q(q); idle(3);
        check("clear_pulse", 32'(n_clr), 32'd1);
        clr_counts();
        q = '{8'hFE, 8'h05, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'hEF};
        send_q(q); idle(3);
        check("clear_size0_err", 32'(n_err), 32'd1);
        check("clear_size0_vec", 32'(vec_q.size()), 32'd0);

        // Timeout after FE 02
        clr_counts();
        send(8'hFE); send(8'h02);
        idle(TMO - 1);
        check("tmo_busy_before", 32'(busy), 32'd1);
        check("tmo_err_before", 32'(n_err), 32'd0);
        idle(1);
        check("tmo_err_pulse", 32'(frame_err), 32'd1);
        check("tmo_busy_fall", 32'(busy), 32'd0);
        idle(4);
        check("tmo_err_once", 32'(n_err), 32'd1);

        // Reset in the middle of a MATRIX payload (N=2)
        q = '{8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF};
        send_q(q); idle(3);
        q = '{8'hFE, 8'h05, 8'h04, 8'hA1, 8'hA2};
        send_q(q);
        rst = 1'b0;
        idle(1);
        check("midrst_outs", 32'(outs()), 32'h0);
        check("midrst_rec", 32'(rec_data), 32'h0);
        idle(2);
        clr_counts();
        rst = 1'b1;
        q = '{8'hA3, 8'hA4, 8'hEF};
        send_q(q); idle(3);
        check("postrst_strobes", 32'(n_size + n_clr + n_start + n_err + mat_q.size() + vec_q.size()), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);
        q = '{8'hFE, 8'h01, 8'h02, 8'hEF};
        send_q(q); idle(3);
        check("postrst_start", 32'(n_start), 32'd1);
        clr_counts();
        q = '{8'hFE, 8'h05, 8'h04, 8'hA0};
        send_q(q); idle(3);
        check("postrst_size0_err", 32'(n_err), 32'd1);

        check("onehot_strobes", 32'(n_multi), 32'd0);
        check("enb_assign_track", 32'(n_enb_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-stream front end for the matrix–vector datapath. It sits between the UART receiver and the data feeder stage. It delimits host frames, validates header, length, command and tail, and tracks the matrix size N. It emits the feeder control strobes (`size_m_en`, `enable_mat`, `enable_vec`, `enb_assign`, `clear`) together with the byte they qualify, plus `start` and `frame_err` pulses for the top-level controller.

## Interface
- `MAX_N`, 8: largest accepted matrix dimension.
- `TIMEOUT_CYCLES`, 50000: inter-byte idle limit inside a frame; width of the timeout counter is `$clog2(TIMEOUT_CYCLES+1)`.
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `rec_data`  out  8  byte qualifying the current strobe.
- `size_m_en`  out  1  one-cycle pulse; `rec_data` = N-1.
- `enable_mat`  out  1  one-cycle pulse per matrix element byte.
- `enable_vec`  out  1  one-cycle pulse per vector element byte.
- `enb_assign`  out  1  high exactly when `enable_mat` or `enable_vec` is high.
- `clear`  out  1  one-cycle pulse; downstream resets its counters.
- `start`  out  1  one-cycle pulse; requests computation.
- `frame_err`  out  1  one-cycle pulse on any rejected frame.
- `busy`  out  1  high while state ≠ IDLE.

## Operation
- Frame format: 0xFE, LEN, CMD, payload[LEN-1], 0xEF. LEN counts the CMD byte plus the payload bytes.
- Commands and required LEN:
  - 0x01 SET_SIZE: LEN=2, payload is N.
  - 0x02 START: LEN=1.
  - 0x03 CLEAR: LEN=1.
  - 0x04 MATRIX: LEN=1+N·N.
  - 0x05 VECTOR: LEN=1+N.
- Internal `size_q` (4 bit) holds N. Reset value is 0, meaning no size set.
- States:
  - IDLE: waits for 0xFE; all other bytes are ignored silently.
  - LEN: captures LEN.
  - CMD: decodes the command and checks LEN against it.
  - PAYLOAD: counts down the remaining payload bytes.
  - TAIL: expects 0xEF.
- LEN=0 is rejected at the LEN state.
- CMD rejection: unknown opcode, LEN mismatch, or MATRIX/VECTOR issued while `size_q`=0. On rejection: `frame_err`, then IDLE.
- A LEN=1 command moves CMD→TAIL.
- MATRIX/VECTOR payload bytes are forwarded on arrival (streamed, not buffered). Values 0xFE and 0xEF inside the payload are data.
- SET_SIZE payload is held in a register. It is committed only at a valid tail: `size_q`←N and `size_m_en` pulses with `rec_data`=N-1.
- SET_SIZE with N=0 or N>`MAX_N`: `frame_err` at the valid tail; `size_q` unchanged.
- START and CLEAR fire their pulse only on a valid tail. CLEAR also sets `size_q`=0.
- Bad tail byte: `frame_err`, return to IDLE, no commit. Streamed data already forwarded is not retracted.
- Timeout: in any state ≠ IDLE, `TIMEOUT_CYCLES` consecutive cycles without `rx_valid` give `frame_err` and a return to IDLE. The counter restarts on every `rx_valid`.
- Product N·N is computed in 7 bits; LEN compare is 8-bit.
- Only one strobe output may be high in any cycle, except `enb_assign` alongside `enable_mat`/`enable_vec`.

## Timing
- All outputs are registered. A strobe appears in the cycle after the `rx_valid` that caused it and lasts exactly 1 cycle.
- `rec_data` holds its last value between strobes.
- Back-to-back `rx_valid` on consecutive cycles is supported with no byte loss, giving at most one strobe per cycle.
- Reset values: every output is 0, `rec_data`=0x00, state IDLE, `size_q`=0, timeout counter 0.
- Asserting `rst` mid-frame aborts the frame with no `frame_err`. The first byte after release is treated as IDLE input.
- `frame_err` and a valid-commit pulse never coincide.
- `busy` rises the cycle after the 0xFE byte and falls the cycle after the tail byte, an error, or a timeout.

## Test plan
- Size set: FE 02 01 03 EF → `size_m_en`=1 for one cycle with `rec_data`=0x02, then `busy`=0; after this, `size_q`=3.
- Matrix load with N=3: FE 0A 04 followed by 9 bytes 10..18, then EF → nine `enable_mat`+`enb_assign` pulses carrying 0x10..0x18 in order, with no `frame_err`.
- Vector load without a size set, after reset: FE 04 05 AA BB CC EF → `frame_err` at CMD; no `enable_vec` pulses; the following bytes are ignored in IDLE.
- Bad tail: FE 01 02 00 → `frame_err`, no `start`; then FE 01 02 EF → `start` pulses once.
- Timeout: FE 02 followed by `TIMEOUT_CYCLES` idle cycles → `frame_err` exactly once; `busy` falls the next cycle.
- Clear and reset: CLEAR frame FE 01 03 EF after N=4 → `clear` pulses and `size_q`=0. Asserting `rst` in the middle of a MATRIX payload → all outputs 0, and no strobes follow until a new valid frame.
